ifetch_prefetch_rv32i: RTL
==========================

Name: ifetch_prefetch_rv32i

Overview:
Instruction fetch front-end that sits directly upstream of the single-cycle RV32I core's instruction input. It fetches words from a variable-latency instruction memory using a req/ack handshake and buffers them in a small FIFO. It presents {instr, instr_pc} with a valid/ready handshake to the core. It discards buffered and in-flight words when the core redirects the PC on a taken branch or a jump.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  32  word-aligned fetch address; stable while imem_req=1
imem_ack  in  1  one-cycle pulse: imem_rdata valid and request complete
imem_rdata  in  32  fetched instruction word
core_ready  in  1  core accepts the head entry this cycle
instr_valid  out  1  head entry valid
instr  out  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0
instr_pc  out  32  PC of head instruction
redirect  in  1  flush and restart fetch (taken branch, JAL, or JALR)
redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0
fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (sync, active-high): imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=0, fifo_count=0, state=IDLE. A reset asserted mid-operation aborts any in-flight request. Any ack that arrives after reset releases is not a valid response and is ignored in IDLE.
- States:
  - IDLE: no request outstanding.
  - WAIT: imem_req=1, waiting for imem_ack.
  - DISCARD: a request is outstanding but its data is stale; the block waits for the ack and drops the data.
- Transitions:
  - IDLE -> WAIT when (fifo_count - pop) < DEPTH, where pop = instr_valid & core_ready. imem_req rises on the edge that enters WAIT. First request: imem_req=1 in the first cycle after reset deasserts, with imem_addr=RESET_PC.
  - WAIT + ack, no redirect: push {imem_rdata, imem_addr}; fetch_pc += 4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0). Go to WAIT if there is still space after this push and pop, otherwise go to IDLE. Back-to-back requests are allowed, so imem_req may stay high across acks.
  - WAIT, no ack, redirect: go to DISCARD; fetch_pc <= redirect_pc.
  - WAIT + ack + redirect in the same cycle: the ack data is dropped; go to IDLE; fetch_pc <= redirect_pc.
  - DISCARD + ack: drop the data. A new redirect in the same cycle overwrites fetch_pc. Go to IDLE.
  - IDLE + redirect: fetch_pc <= redirect_pc. The request is issued no earlier than the next cycle.
- Redirect priority: redirect beats push and pop. The FIFO is cleared on the edge following redirect, so instr_valid=0 and fifo_count=0 in the next cycle. A pop in the redirect cycle is permitted and is irrelevant.
- Request rules:
  - Only one request is outstanding at a time.
  - imem_addr changes only when imem_req=0 or in the cycle after an ack.
  - During DISCARD, imem_addr keeps the stale address; the redirect target is held internally.
- Latency: an ack in cycle N gives instr_valid=1 in cycle N+1 (registered FIFO, no bypass).
- FIFO: simultaneous push and pop leaves the count unchanged. A push at count=DEPTH cannot occur because request gating prevents it; the bench asserts this. A pop at count=0 is ignored.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined: adds the outputs perf_starve_cnt[31:0] and perf_flush_cnt[31:0], both saturating, both cleared by reset.
  - perf_starve_cnt increments each cycle with core_ready=1 and instr_valid=0.
  - perf_flush_cnt increments on each redirect cycle.
- Undefined: both ports and their logic are absent.

Decomposition:
- Package rv32i_ifetch_pkg holds:
  - XLEN=32
  - NOP_INSTR=32'h0000_0013
  - PC_STEP=4
  - fetch state enum {IDLE, WAIT, DISCARD}
- Sub-module fifo_sync_rv32i(WIDTH=64, DEPTH) with push, pop, clear, full, empty and count. It is reused later for store buffering.

Test Plan:
- Reset, then ack one cycle after each req, core_ready=1 -> imem_addr 0,4,8,...; instr_pc follows each ack by one cycle; instr equals the ROM contents.
- core_ready=0, DEPTH=4 -> after 4 acks imem_req=0 and fifo_count=4; core_ready=1 for one cycle -> imem_req reasserts at addr 16 the next cycle.
- redirect=1, redirect_pc=32'h0000_0103 while IDLE with count=3 -> next cycle instr_valid=0, count=0; the next request uses imem_addr=32'h0000_0100; the first valid instr_pc is 0x100.
- redirect during WAIT, ack 3 cycles later with data 0xDEADBEEF -> 0xDEADBEEF never appears on instr; the following request is at redirect_pc. Also cover redirect coinciding with ack: the data is dropped.
- redirect_pc=32'hFFFF_FFFC -> two consecutive fetches at 0xFFFF_FFFC then 0x0000_0000.
- reset pulsed during WAIT -> all outputs return to reset values; the late ack is ignored; the next request is at RESET_PC.

Source files
------------

// File: rtl/ifetch_prefetch_rv32i_pkg.sv
// Shared types and constants for the RV32I instruction fetch front-end.
// No ports: this package is imported by ifetch_prefetch_rv32i and fifo users.
// Holds XLEN, the canonical NOP, the PC step, the fetch FSM state and FIFO entry layout.
package rv32i_ifetch_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  // One FIFO entry: instruction word in the upper half, its PC in the lower half.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_prefetch_rv32i_fifo.sv
// Purpose: generic synchronous FIFO (module fifo_sync_rv32i), registered storage, no bypass.
// Latency: a push in cycle N is visible at the head in cycle N+1.
// Backpressure: push while full and pop while empty are ignored; clear wins over push/pop.
// Ports: i_clock, i_reset (sync, active-high), i_push/i_push_dat, i_pop, i_clear,
//        o_head_dat, o_full, o_empty, o_count.
module fifo_sync_rv32i #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_push_dat,
  input  logic                           i_pop,
  input  logic                           i_clear,
  output logic [WIDTH-1:0]               o_head_dat,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_prefetch_rv32i.sv
// Purpose: RV32I fetch front-end; req/ack instruction memory -> FIFO -> valid/ready to the core.
// Latency: imem ack in cycle N gives o_instr_valid in cycle N+1; redirect empties the FIFO next cycle.
// Backpressure: a new fetch is only issued while the FIFO has room after this cycle's pop.
// Ports: i_clock, i_reset; o_imem_req/o_imem_addr/i_imem_ack/i_imem_rdata (memory side);
//        o_instr_valid/o_instr/o_instr_pc/i_core_ready (core side); i_redirect/i_redirect_pc;
//        o_fifo_count. With IFETCH_PERF_EN defined: o_perf_starve_cnt, o_perf_flush_cnt.
module ifetch_prefetch_rv32i
  import rv32i_ifetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  output logic                        o_imem_req,
  output logic [XLEN-1:0]             o_imem_addr,
  input  logic                        i_imem_ack,
  input  logic [XLEN-1:0]             i_imem_rdata,
  input  logic                        i_core_ready,
  output logic                        o_instr_valid,
  output logic [XLEN-1:0]             o_instr,
  output logic [XLEN-1:0]             o_instr_pc,
  input  logic                        i_redirect,
  input  logic [XLEN-1:0]             i_redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]  o_fifo_count
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]                 o_perf_starve_cnt,
  output logic [31:0]                 o_perf_flush_cnt
`endif
);

  localparam int          CW      = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  fetch_state_t    r_state;
  logic            r_req;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_fetch_pc;   // next address to request; holds redirect target during DISCARD

  fetch_entry_t    w_head;
  fetch_entry_t    w_push_dat;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_after_pop;
  logic [CW:0]     w_after_push;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_redirect_pc = align_pc(i_redirect_pc);
  assign w_next_pc     = r_addr + PC_STEP;        // wraps modulo 2^32
  assign w_pop         = ~w_empty & i_core_ready;
  // Redirect beats push: data acked in the redirect cycle belongs to the old path.
  assign w_push        = (r_state == WAIT) & i_imem_ack & ~i_redirect & ~w_full;
  assign w_push_dat    = '{instr: i_imem_rdata, pc: r_addr};

  // Occupancy as seen after this cycle's pop (and push); one extra bit avoids wrap.
  assign w_after_pop  = {1'b0, w_count} - {{CW{1'b0}}, w_pop};
  assign w_after_push = w_after_pop + {{CW{1'b0}}, w_push};

  fifo_sync_rv32i #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_clear    (i_redirect),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_instr_valid = ~w_empty;
  assign o_instr       = w_empty ? NOP_INSTR : w_head.instr;
  assign o_instr_pc    = w_empty ? '0 : w_head.pc;
  assign o_fifo_count  = w_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          // Late acks are ignored here; a redirect only retargets, the request follows later.
          if (i_redirect) begin
            r_fetch_pc <= w_redirect_pc;
          end else if (w_after_pop < DEPTH_V) begin
            r_state <= WAIT;
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
          end
        end
        WAIT: begin
          if (i_imem_ack) begin
            if (i_redirect) begin
              r_fetch_pc <= w_redirect_pc;
              r_state    <= IDLE;
              r_req      <= 1'b0;
            end else begin
              r_fetch_pc <= w_next_pc;
              if (w_after_push < DEPTH_V) begin
                r_addr <= w_next_pc;     // back-to-back: req stays high
              end else begin
                r_state <= IDLE;
                r_req   <= 1'b0;
              end
            end
          end else if (i_redirect) begin
            // Keep the stale address on the bus until its ack retires it.
            r_state    <= DISCARD;
            r_fetch_pc <= w_redirect_pc;
          end
        end
        DISCARD: begin
          if (i_redirect) r_fetch_pc <= w_redirect_pc;
          if (i_imem_ack) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_starve;
  logic [31:0] r_perf_flush;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_perf_starve <= '0;
      r_perf_flush  <= '0;
    end else begin
      if (i_core_ready && !o_instr_valid && (r_perf_starve != '1)) r_perf_starve <= r_perf_starve + 32'd1;
      if (i_redirect && (r_perf_flush != '1))                      r_perf_flush  <= r_perf_flush + 32'd1;
    end
  end

  assign o_perf_starve_cnt = r_perf_starve;
  assign o_perf_flush_cnt  = r_perf_flush;
`endif

endmodule
